// File: rtl/alu_seq.sv
// alu_seq: registered EX-stage ALU with valid/ready handshake and iterative MULU/DIVU
// Ports: clock/resetn (sync, active-low); in_valid/in_ready accept a, b, aluc;
// out_valid/out_ready hand over s, z (s==0), le (signed a<=b); busy marks an iteration in progress.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic             le,
  output logic             busy
);
  localparam int SHW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d, s_q, s_d;
  logic [1:0]         op_q, op_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic               le_q, le_d;
  logic [SHW-1:0]     sh;
  logic               le_in, go_calc;
  logic [WIDTH-1:0]   res, mul_add, fin;
  logic [WIDTH:0]     mul_sum, div_sh, div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] step;
  function automatic logic [WIDTH-1:0] popcnt(input logic [WIDTH-1:0] v);
    popcnt = '0;
    for (int i = 0; i < WIDTH; i++) popcnt = popcnt + WIDTH'(v[i]);
  endfunction
  assign sh      = a[SHW-1:0];
  assign le_in   = $signed(a) <= $signed(b);
  // MULU/DIVU iterate unless it is a divide by zero, which resolves at accept
  assign go_calc = aluc[4:2] == 3'b100 && !(aluc[1] && b == '0);
  always_comb begin
    res = '0;
    casez (aluc)
      5'b0?000: res = a + b;
      5'b0?100: res = a - b;
      5'b0?001: res = a & b;
      5'b0?101: res = a | b;
      5'b0?010: res = a ^ b;
      5'b0?110: res = b << (WIDTH / 2);
      5'b00011: res = b << sh;
      5'b00111: res = b >> sh;
      5'b01111: res = $signed(b) >>> sh;
      5'b01011: res = popcnt(a ^ b);
      5'b10010: res = '1;
      5'b10011: res = a;
      5'b10100: res = popcnt(a);
      5'b10101: res = WIDTH'(le_in);
      default:  res = '0;
    endcase
  end
  // acc holds {hi, lo}: MUL {partial, multiplier}, DIV {remainder, dividend/quotient}
  assign mul_add = acc_q[0] ? opnd_q : '0;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add};
  assign div_sh  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_ge  = div_sh >= {1'b0, opnd_q};
  assign div_rem = div_ge ? div_sh - {1'b0, opnd_q} : div_sh;
  assign step    = op_q[1] ? {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge}
                           : {mul_sum, acc_q[WIDTH-1:1]};
  assign fin     = op_q[0] ? step[2*WIDTH-1:WIDTH] : step[WIDTH-1:0];
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    le_d    = le_q;
    case (state_q)
      IDLE: if (in_valid) begin
        le_d    = le_in;
        op_d    = aluc[1:0];
        opnd_d  = aluc[1] ? b : a;
        acc_d   = {{WIDTH{1'b0}}, aluc[1] ? a : b};
        cnt_d   = '0;
        state_d = go_calc ? CALC : DONE;
        s_d     = go_calc ? s_q : res;
      end
      CALC: begin
        acc_d   = step;
        cnt_d   = cnt_q + SHW'(1);
        state_d = cnt_q == SHW'(WIDTH - 1) ? DONE : CALC;
        s_d     = cnt_q == SHW'(WIDTH - 1) ? fin : s_q;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opnd_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      le_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      le_q    <= le_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q == CALC;
  assign s         = s_q;
  assign z         = ~|s_q;
  assign le        = le_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq (WIDTH=32) against an arithmetic reference
module tb_alu_seq;
  logic        clock = 1'b0, resetn = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  aluc = '0;
  logic        in_ready, out_valid, z, le, busy;
  logic [31:0] s;
  int n_vec = 0, n_err = 0;
  alu_seq #(.WIDTH(32)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .aluc(aluc), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .z(z), .le(le), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [31:0] ref_s(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    logic [4:0]  sh;
    p  = {32'b0, x} * {32'b0, y};
    sh = x[4:0];
    if (op[4]) begin
      case (op[3:0])
        4'd0:    return p[31:0];
        4'd1:    return p[63:32];
        4'd2:    return y == 0 ? 32'hFFFF_FFFF : x / y;
        4'd3:    return y == 0 ? x : x % y;
        4'd4:    return 32'($countones(x));
        4'd5:    return {31'b0, $signed(x) <= $signed(y)};
        default: return 32'b0;
      endcase
    end
    case (op[2:0])
      3'd0: return x + y;
      3'd4: return x - y;
      3'd1: return x & y;
      3'd5: return x | y;
      3'd2: return x ^ y;
      3'd6: return y << 16;
      default: begin
        case (op[3:2])
          2'b00:   return y << sh;
          2'b01:   return y >> sh;
          2'b11:   return $signed(y) >>> sh;
          default: return 32'($countones(x ^ y));
        endcase
      end
    endcase
  endfunction
  task automatic run(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                     input int hold, input bit early);
    logic [31:0] es;
    logic        el;
    int          lat, nb, exp_lat;
    es      = ref_s(op, x, y);
    el      = $signed(x) <= $signed(y);
    exp_lat = (op[4:2] == 3'b100 && !(op[1] && y == 0)) ? 33 : 1;
    chk("ready_before_accept", 64'(in_ready), 64'(1));
    in_valid  = 1'b1;
    aluc      = op;
    a         = x;
    b         = y;
    out_ready = early;
    tick();
    a    = $urandom;
    b    = $urandom;
    aluc = 5'($urandom);
    lat  = 1;
    nb   = 0;
    while (!out_valid && lat < 100) begin
      if (busy) nb++;
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_cycles", 64'(nb), 64'(exp_lat - 1));
    chk("s", 64'(s), 64'(es));
    chk("z", 64'(z), 64'(es == 0));
    chk("le", 64'(le), 64'(el));
    repeat (hold) begin
      tick();
      chk("hold_valid", 64'(out_valid), 64'(1));
      chk("hold_in_ready", 64'(in_ready), 64'(0));
      chk("hold_s", 64'(s), 64'(es));
      chk("hold_z", 64'(z), 64'(es == 0));
      chk("hold_le", 64'(le), 64'(el));
    end
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("drained", 64'(out_valid), 64'(0));
    chk("back_idle", 64'(in_ready), 64'(1));
  endtask
  initial begin
    int nb;
    logic [4:0]  op;
    logic [31:0] x, y;
    int          hold;
    repeat (2) tick();
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_s", 64'(s), 64'(0));
    chk("rst_z", 64'(z), 64'(1));
    chk("rst_le", 64'(le), 64'(0));
    resetn = 1'b1;
    tick();
    run(5'b00000, 32'h7FFF_FFFF, 32'h1, 0, 1'b0);
    run(5'b00100, 32'd5, 32'd5, 3, 1'b0);
    run(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b0);
    run(5'b10010, 32'd100, 32'd7, 0, 1'b0);
    run(5'b10011, 32'd100, 32'd7, 0, 1'b1);
    run(5'b10010, 32'd100, 32'd0, 0, 1'b0);
    run(5'b10011, 32'd100, 32'd0, 0, 1'b1);
    run(5'b01111, 32'h24, 32'h8000_0000, 0, 1'b0);
    run(5'b01011, 32'hF0F0_F0F0, 32'h0, 0, 1'b0);
    run(5'b10101, 32'hFFFF_FFFF, 32'h0, 0, 1'b1);
    run(5'b11000, 32'h1234, 32'h5678, 0, 1'b0);
    in_valid = 1'b1;
    aluc     = 5'b10010;
    a        = 32'd100;
    b        = 32'd7;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    chk("div_busy_mid", 64'(busy), 64'(1));
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    chk("abort_out_valid", 64'(out_valid), 64'(0));
    chk("abort_in_ready", 64'(in_ready), 64'(1));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_z", 64'(z), 64'(1));
    chk("abort_s", 64'(s), 64'(0));
    chk("abort_le", 64'(le), 64'(0));
    nb = 0;
    repeat (40) begin
      tick();
      if (out_valid) nb++;
    end
    chk("abort_no_result", 64'(nb), 64'(0));
    run(5'b00000, 32'd2, 32'd3, 0, 1'b0);
    for (int i = 0; i < 80; i++) begin
      op   = 5'($urandom_range(0, 31));
      x    = $urandom;
      y    = $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 3)) : $urandom;
      hold = $urandom_range(0, 2);
      run(op, x, y, hold, hold == 0 && $urandom_range(0, 1) == 1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
